// File: rtl/passcode_checker_pkg.sv
// Shared key codes, FSM state encoding and helpers for the passcode checker.
// Imported by the interface, the key event synchronizer and the top level.
package passcode_checker_pkg;

    localparam int TIMER_W = 28;

    localparam logic [3:0] KEY_STAR   = 4'd13;
    localparam logic [3:0] KEY_HASH   = 4'd14;
    localparam logic [3:0] KEY_LETTER = 4'd15;

    typedef enum logic [2:0] {
        ST_ENTRY    = 3'd0,
        ST_CHECK    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_FAIL     = 3'd3,
        ST_LOCKOUT  = 3'd4
    } state_t;

    // Selects the low 4*len bits of a 16-bit BCD code.
    function automatic logic [15:0] code_mask(input int len);
        logic [15:0] m;
        m = 16'h0;
        for (int i = 0; i < 4; i++) begin
            if (i < len) m[4*i +: 4] = 4'hF;
        end
        return m;
    endfunction

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/passcode_checker_if.sv
// Keypad-side inputs and door/display-side outputs of the passcode checker.
// Handshake: key_strobe is an asynchronous level; its rising edge marks one key, key_value is stable while it is high.
interface passcode_checker_if;
    import passcode_checker_pkg::*;

    logic [3:0]  key_value;
    logic        key_strobe;
    logic        unlock;
    logic        error;
    logic        alarm;
    logic [2:0]  digit_count;
    logic [15:0] entry_code;
    logic [2:0]  fail_count;
    state_t      state;

    modport master (
        output key_value, key_strobe,
        input  unlock, error, alarm, digit_count, entry_code, fail_count, state
    );

    modport slave (
        input  key_value, key_strobe,
        output unlock, error, alarm, digit_count, entry_code, fail_count, state
    );

endinterface

// File: rtl/passcode_checker_key_event_sync.sv
// Two-flop synchronizer for the scanner strobe followed by a rising-edge detector.
// Produces a single-cycle key event per press no matter how long the strobe is held.
module key_event_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_key_strobe,
    output logic o_key_evt
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_key_strobe;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_key_evt = r_sync2 & ~r_prev;

endmodule

// File: rtl/passcode_checker.sv
// Collects keypad digits, checks them against the stored passcode on '#',
// and drives timed unlock, error and lockout-alarm outputs.
module passcode_checker
    import passcode_checker_pkg::*;
#(
    parameter int                  CODE_LEN       = 4,
    parameter logic [15:0]         DEFAULT_CODE   = 16'h1234,
    parameter int                  MAX_FAIL       = 3,
    parameter logic [TIMER_W-1:0]  UNLOCK_CYCLES  = 28'd100_000_000,
    parameter logic [TIMER_W-1:0]  FAIL_CYCLES    = 28'd50_000_000,
    parameter logic [TIMER_W-1:0]  LOCKOUT_CYCLES = 28'd250_000_000
) (
    input  logic               clk,
    input  logic               rst,
    passcode_checker_if.slave  bus
);

    localparam logic [2:0]         LEN3         = 3'(CODE_LEN);
    localparam logic [2:0]         MAX3         = 3'(MAX_FAIL);
    localparam logic [15:0]        CODE_MASK    = code_mask(CODE_LEN);
    localparam logic [TIMER_W-1:0] UNLOCK_LAST  = UNLOCK_CYCLES - TIMER_W'(1);
    localparam logic [TIMER_W-1:0] FAIL_LAST    = FAIL_CYCLES - TIMER_W'(1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LAST = LOCKOUT_CYCLES - TIMER_W'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic [TIMER_W-1:0] r_timer;
    logic [15:0]        r_entry_code;
    logic [2:0]         r_digit_count;
    logic [2:0]         r_fail_count;
    logic               r_unlock;
    logic               r_error;
    logic               r_alarm;

    logic               w_key_evt;
    logic [3:0]         w_key;
    logic               w_match;
    logic [2:0]         w_fail_inc;
    logic               w_unlock_d;
    logic               w_error_d;
    logic               w_alarm_d;

    key_event_sync u_key_event_sync (
        .clk          (clk),
        .rst          (rst),
        .i_key_strobe (bus.key_strobe),
        .o_key_evt    (w_key_evt)
    );

    assign w_key      = bus.key_value;
    assign w_match    = ((r_entry_code ^ DEFAULT_CODE) & CODE_MASK) == 16'h0;
    assign w_fail_inc = r_fail_count + 3'd1;

    // Outputs are registered from the next state so they move on the transition edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_ENTRY;
            r_unlock <= 1'b0;
            r_error  <= 1'b0;
            r_alarm  <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_unlock <= w_unlock_d;
            r_error  <= w_error_d;
            r_alarm  <= w_alarm_d;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ENTRY: begin
                if (w_key_evt && (w_key == KEY_HASH) && (r_digit_count == LEN3))
                    w_next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_match)
                    w_next_state = ST_UNLOCKED;
                else if (w_fail_inc == MAX3)
                    w_next_state = ST_LOCKOUT;
                else
                    w_next_state = ST_FAIL;
            end
            ST_UNLOCKED: begin
                if ((w_key_evt && (w_key == KEY_STAR)) || (r_timer == UNLOCK_LAST))
                    w_next_state = ST_ENTRY;
            end
            ST_FAIL: begin
                if (r_timer == FAIL_LAST) w_next_state = ST_ENTRY;
            end
            ST_LOCKOUT: begin
                if (r_timer == LOCKOUT_LAST) w_next_state = ST_ENTRY;
            end
            default: w_next_state = ST_ENTRY;
        endcase
    end

    always_comb begin
        w_unlock_d = (w_next_state == ST_UNLOCKED);
        w_error_d  = (w_next_state == ST_FAIL);
        w_alarm_d  = (w_next_state == ST_LOCKOUT);
    end

    // Timer restarts on every state change and only runs in the timed states.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer       <= '0;
            r_entry_code  <= 16'h0;
            r_digit_count <= 3'd0;
            r_fail_count  <= 3'd0;
        end else begin
            if (w_next_state != r_state)
                r_timer <= '0;
            else if ((r_state == ST_UNLOCKED) || (r_state == ST_FAIL) || (r_state == ST_LOCKOUT))
                r_timer <= r_timer + TIMER_W'(1);

            case (r_state)
                ST_ENTRY: begin
                    if (w_key_evt) begin
                        if (is_digit(w_key) && (r_digit_count < LEN3)) begin
                            r_entry_code  <= {r_entry_code[11:0], w_key};
                            r_digit_count <= r_digit_count + 3'd1;
                        end else if (w_key == KEY_STAR) begin
                            r_entry_code  <= 16'h0;
                            r_digit_count <= 3'd0;
                        end
                    end
                end
                ST_CHECK: begin
                    r_entry_code  <= 16'h0;
                    r_digit_count <= 3'd0;
                    r_fail_count  <= w_match ? 3'd0 : w_fail_inc;
                end
                ST_LOCKOUT: begin
                    if (w_next_state == ST_ENTRY) r_fail_count <= 3'd0;
                end
                default: ;
            endcase
        end
    end

    assign bus.unlock      = r_unlock;
    assign bus.error       = r_error;
    assign bus.alarm       = r_alarm;
    assign bus.digit_count = r_digit_count;
    assign bus.entry_code  = r_entry_code;
    assign bus.fail_count  = r_fail_count;
    assign bus.state       = r_state;

endmodule
